// File: rtl/button_event_unit.sv
// Button event unit: per-channel debounce / short / long press detection,
// event queue and an AHB-Lite register slave.
module button_event_unit #(
  parameter int NUM_BTN     = 4,
  parameter int DEB_CYCLES  = 900,
  parameter int LONG_CYCLES = 16000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic               HSEL,
  input  logic [2:0]         HSIZE,
  input  logic [1:0]         HTRANS,
  input  logic [NUM_BTN-1:0] Btn,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               Irq
);
  localparam int CNTW = $clog2(LONG_CYCLES + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, LONG} state_t;

  logic [NUM_BTN-1:0] sync1, line, armed;
  logic [1:0]         warm;
  state_t             state [NUM_BTN];
  state_t             state_nxt [NUM_BTN];
  logic [CNTW-1:0]    cnt [NUM_BTN];
  logic [CNTW-1:0]    cnt_nxt [NUM_BTN];
  logic [NUM_BTN-1:0] short_set, long_set, short_pend, long_pend;
  logic [NUM_BTN-1:0] sel_oh, short_clr, long_clr, en_mask, pressed;
  logic               found, sel_long, irq_en, ovf;
  logic [2:0]         sel_idx;
  logic [8:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               full, empty, pop, do_push, drop;
  logic               a_vld, a_write;
  logic [1:0]         a_addr;
  logic [31:0]        rd_c, rd_e;

  wire unused_ok = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA};

  assign HREADYOUT = 1'b1;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign Irq       = irq_en & ~empty;

  // Two-flop synchroniser (idle-high); warm marks when sync output is real input.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sync1 <= '1;
      line  <= '1;
      warm  <= '0;
      armed <= '0;
    end else begin
      sync1 <= Btn;
      line  <= sync1;
      warm  <= {warm[0], 1'b1};
      // A channel only accepts a press after it has been seen released,
      // so a button held through reset stays silent.
      armed <= armed | ({NUM_BTN{warm[1]}} & line);
    end
  end

  // Per-channel press FSM next state, counters and event raises.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      short_set[i] = 1'b0;
      long_set[i]  = 1'b0;
      pressed[i]   = (state[i] == HELD) || (state[i] == LONG);
      case (state[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (armed[i] && !line[i]) begin
            state_nxt[i] = DEBOUNCE;
            cnt_nxt[i]   = CNTW'(1);
          end
        end
        DEBOUNCE: begin
          if (line[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else begin
            cnt_nxt[i] = cnt[i] + CNTW'(1);
            if (cnt[i] == CNTW'(DEB_CYCLES)) begin
              state_nxt[i] = HELD;
              short_set[i] = en_mask[i];
            end
          end
        end
        HELD: begin
          if (line[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == CNTW'(LONG_CYCLES)) begin
            state_nxt[i] = LONG;
            long_set[i]  = en_mask[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CNTW'(1);
          end
        end
        default: begin
          // LONG: counter holds at LONG_CYCLES until release.
          if (line[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end
        end
      endcase
    end
  end

  // Per-channel FSM state and counter registers.
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < NUM_BTN; i++) begin
      if (HRESET) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // Arbiter: lowest pending channel wins; SHORT drains before LONG.
  always_comb begin
    found   = 1'b0;
    sel_oh  = '0;
    sel_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (short_pend[i] || long_pend[i]) begin
        found     = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_idx   = 3'(i);
      end
    end
    short_clr = sel_oh & short_pend;
    long_clr  = sel_oh & ~short_pend & long_pend;
    sel_long  = |long_clr;
  end

  assign pop     = a_vld && !a_write && (a_addr == 2'd0) && !empty;
  assign do_push = found && (!full || pop);
  assign drop    = found && full && !pop;

  // Pending flags, FIFO, overflow and control registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      short_pend <= '0;
      long_pend  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      en_mask    <= '1;
      irq_en     <= 1'b0;
    end else begin
      // Masking with the current enable drops flags of disabled channels.
      short_pend <= ((short_pend & ~short_clr) | short_set) & en_mask;
      long_pend  <= ((long_pend & ~long_clr) | long_set) & en_mask;
      if (do_push) begin
        mem[wr_ptr] <= {sel_long, 5'b0, sel_idx};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
      if (drop)
        ovf <= 1'b1;
      else if (a_vld && a_write && a_addr == 2'd1 && HWDATA[31])
        ovf <= 1'b0;
      if (a_vld && a_write && a_addr == 2'd3) begin
        en_mask <= HWDATA[NUM_BTN-1:0];
        irq_en  <= HWDATA[31];
      end
    end
  end

  // AHB address phase capture; data phase follows with no wait states.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_vld   <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
    end else begin
      a_vld   <= HSEL && HREADY && HTRANS[1];
      a_write <= HWRITE;
      a_addr  <= HADDR[3:2];
    end
  end

  // Read mux for the data phase.
  always_comb begin
    rd_c = '0;
    rd_e = '0;
    HRDATA = '0;
    rd_e[NUM_BTN-1:0] = en_mask;
    rd_e[31] = irq_en;
    rd_c[NUM_BTN-1:0] = pressed;
    if (a_vld && !a_write) begin
      case (a_addr)
        2'd0:    HRDATA = empty ? 32'h0 : {1'b1, 22'b0, mem[rd_ptr]};
        2'd1:    HRDATA = {ovf, 13'b0, full, empty, 10'b0, 6'(count)};
        2'd2:    HRDATA = rd_c;
        default: HRDATA = rd_e;
      endcase
    end
  end
endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit with default parameters.
module tb_button_event_unit;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HREADY, HSEL, HREADYOUT, Irq;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  Btn;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] d;

  button_event_unit dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .Btn(Btn), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .Irq(Irq)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] rd);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    rd = HRDATA;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] wd);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
    @(posedge HCLK); #1;
  endtask

  task automatic press(input logic [3:0] mask, input int n);
    Btn = Btn & ~mask;
    repeat (n) @(posedge HCLK);
    #1 Btn = Btn | mask;
    repeat (10) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
  endtask

  initial begin
    HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0;
    HSIZE = 3'd2; HTRANS = 2'b00; Btn = 4'hF;
    do_reset();
    repeat (5) @(posedge HCLK);
    #1;

    // Reset state
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_irq", {31'b0, Irq}, 32'h0);
    chk("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    ahb_read(32'h4, d); chk("rst_status", d, 32'h0001_0000);
    ahb_read(32'hC, d); chk("rst_ctrl", d, 32'h0000_000F);
    ahb_read(32'h0, d); chk("rst_empty_read", d, 32'h0);

    ahb_write(32'hC, 32'h8000_000F);

    // Single short press on channel 1
    press(4'b0010, 1000);
    ahb_read(32'h4, d); chk("short_status", d, 32'h0000_0001);
    chk("short_irq", {31'b0, Irq}, 32'h1);
    ahb_read(32'h0, d); chk("short_event", d, 32'h8000_0001);
    ahb_read(32'h4, d); chk("short_after_pop", d, 32'h0001_0000);
    chk("short_irq_clr", {31'b0, Irq}, 32'h0);

    // Glitch shorter than debounce
    press(4'b0001, 500);
    ahb_read(32'h4, d); chk("glitch_status", d, 32'h0001_0000);
    chk("glitch_irq", {31'b0, Irq}, 32'h0);

    // Long press on channel 2
    press(4'b0100, 20000);
    ahb_read(32'h4, d); chk("long_status", d, 32'h0000_0002);
    ahb_read(32'h0, d); chk("long_ev_short", d, 32'h8000_0002);
    ahb_read(32'h0, d); chk("long_ev_long", d, 32'h8000_0102);
    ahb_read(32'h0, d); chk("long_no_third", d, 32'h0);

    // Simultaneous press on channels 0 and 3
    press(4'b1001, 1000);
    ahb_read(32'h0, d); chk("simul_first", d, 32'h8000_0000);
    ahb_read(32'h0, d); chk("simul_second", d, 32'h8000_0003);

    // Channel 1 disabled: state visible, no event
    ahb_write(32'hC, 32'h8000_000D);
    Btn[1] = 1'b0;
    repeat (1000) @(posedge HCLK);
    ahb_read(32'h8, d); chk("dis_pressed", d, 32'h0000_0002);
    #1 Btn[1] = 1'b1;
    repeat (10) @(posedge HCLK);
    ahb_read(32'h4, d); chk("dis_no_event", d, 32'h0001_0000);
    ahb_write(32'hC, 32'h8000_000F);

    // Ten events into an 8-deep queue
    for (int k = 0; k < 10; k++) press(4'(1 << (k % 4)), 950);
    ahb_read(32'h4, d); chk("ovf_status", d, 32'h8002_0008);
    ahb_write(32'h4, 32'h8000_0000);
    ahb_read(32'h4, d); chk("ovf_cleared", d, 32'h0002_0008);
    for (int k = 0; k < 8; k++) begin
      ahb_read(32'h0, d);
      chk($sformatf("ovf_ev%0d", k), d, 32'h8000_0000 | 32'(k % 4));
    end
    ahb_read(32'h4, d); chk("ovf_drained", d, 32'h0001_0000);

    // Reset during a held press
    Btn[0] = 1'b0;
    repeat (1000) @(posedge HCLK);
    #1 do_reset();
    repeat (1500) @(posedge HCLK);
    ahb_read(32'h4, d); chk("rstmid_status", d, 32'h0001_0000);
    ahb_read(32'h8, d); chk("rstmid_pressed", d, 32'h0);
    chk("rstmid_irq", {31'b0, Irq}, 32'h0);
    #1 Btn[0] = 1'b1;
    repeat (10) @(posedge HCLK);
    press(4'b0001, 1000);
    ahb_read(32'h0, d); chk("rstmid_repress", d, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/button_event_unit.md
BUTTON_EVENT_UNIT -- requirements
Module: button_event_unit

Interface
REQ-001 Parameter NUM_BTN, default 4, number of button channels (1..8).
REQ-002 Parameter DEB_CYCLES, default 900, debounce hold time in HCLK cycles (>=2).
REQ-003 Parameter LONG_CYCLES, default 16000, hold time qualifying a long press (>DEB_CYCLES).
REQ-004 Parameter FIFO_DEPTH, default 8, event queue depth (power of two, 2..32).
REQ-005 Port HCLK  in  1  sole clock; all logic on rising edge.
REQ-006 Port HRESET  in  1  reset, synchronous, active-high.
REQ-007 Ports HADDR[31:0], HWDATA[31:0], HWRITE, HREADY, HSEL, HSIZE[2:0], HTRANS[1:0]  in  AHB-Lite slave inputs; only HADDR[3:2] decoded; HSIZE ignored (word only).
REQ-008 Port Btn  in  NUM_BTN  raw button lines, asynchronous, active-low (pressed = 0).
REQ-009 Port HRDATA  out  32  read data; HREADYOUT  out  1  tied 1.
REQ-010 Port Irq  out  1  high while FIFO non-empty and IrqEn set.

Function
REQ-011 Each Btn bit SHALL pass a 2-flop synchroniser before any other use.
REQ-012 Per channel FSM SHALL have states IDLE, DEBOUNCE, HELD, LONG.
REQ-013 IDLE->DEBOUNCE on synchronised 1->0 edge; counter loads 1.
REQ-014 DEBOUNCE: if line returns 1 -> IDLE, no event; at count == DEB_CYCLES -> HELD, raise SHORT pending flag only if channel enabled.
REQ-015 HELD: counter continues; at count == LONG_CYCLES -> LONG, raise LONG pending flag if enabled; line 1 -> IDLE.
REQ-016 LONG: no further events; line 1 -> IDLE; counter saturates, never wraps.
REQ-017 Event word SHALL be {23'b0, long(1), 5'b0, index(3)}; FIFO width 9 bits stored.
REQ-018 Arbiter SHALL push at most one pending flag per cycle, lowest index first, SHORT before LONG within a channel; flag cleared when pushed or dropped.
REQ-019 Push when FIFO full and no pop in same cycle: event dropped, sticky Overflow set.
REQ-020 Push and pop in same cycle: both performed, count unchanged, accepted even when full.
REQ-021 AHB address phase registered (HSEL & HREADY & HTRANS[1]); data phase next cycle, zero wait states.
REQ-022 Addr 0x0 read: HRDATA = {valid(bit31), event word}; pops head in data phase; empty read returns 0, no pop.
REQ-023 Addr 0x4 read: {Overflow(bit31), Full(bit17), Empty(bit16), Count[5:0]}; write with HWDATA[31]=1 clears Overflow.
REQ-024 Addr 0x8 read: debounced pressed state per channel in bits [NUM_BTN-1:0] (1 = HELD or LONG); writes ignored.
REQ-025 Addr 0xC read/write: Enable mask bits [NUM_BTN-1:0], IrqEn bit 31; disabling a channel clears its pending flags next cycle, does not flush FIFO.
REQ-026 Writes to 0x0 ignored; reads of write-only bits return 0; unused HRDATA bits 0.
REQ-027 Count SHALL be ceil(log2(FIFO_DEPTH))+1 bits; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 HRESET high at a rising edge SHALL force: all FSMs IDLE, counters 0, pending flags 0, FIFO empty, Overflow 0, Enable mask all 1, IrqEn 0, Irq 0, address-phase registers idle (HRDATA 0).
REQ-029 Reset mid-press: after release of reset, a still-low Btn SHALL produce no event until released and pressed again (synchroniser reset to 1).

Verification
REQ-030 Btn[1] low for 1000 cycles then high -> exactly one event 0x00000001 readable at 0x0 with bit31 set; Count returns 0 after read.
REQ-031 Btn[0] glitch low 500 cycles -> no event, Empty=1, Irq stays 0.
REQ-032 Btn[2] held 20000 cycles -> SHORT 0x002 then LONG 0x102 in order, no third event.
REQ-033 Btn[0] and Btn[3] fall same cycle -> events index 0 then 3 in consecutive FIFO slots.
REQ-034 Generate 10 events with default depth, no reads -> Count=8, Full=1, Overflow=1; first 8 events preserved; write 0x80000000 to 0x4 clears Overflow.
REQ-035 Disable channel 1 via 0xC, press it 1000 cycles -> no event; Btn[1] still shown pressed at 0x8.
